// File: rtl/uart_rx_sequencer.sv
// Purpose: UART receive sequencer: arms the start detector, samples mid-bit, assembles LSB-first bytes.
// Latency: byte visible one clk after the stop-bit sample edge, (DATA_BITS+1)*CLKS_PER_BIT edges after start.
// Backpressure: one-entry buffer held until rx_ready; a byte completing into a full buffer is dropped with overrun.
module uart_rx_sequencer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data,
  input  logic                 start_bit_detected,
  output logic                 detector_rst,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA      = 2'd1,
    STOP      = 2'd2,
    WAIT_IDLE = 2'd3
  } state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 frame_done;
  logic                 frame_err;

  assign busy = (state != IDLE);

  // Next-state logic: bit timing, LSB-first shifting and stop-bit verdict.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    shreg_n    = shreg;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    case (state)
      IDLE: begin
        if (start_bit_detected) begin
          state_n = DATA;
          cnt_n   = CNT_MAX;
          idx_n   = '0;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          // New bits enter at the top so the first bit ends up in bit 0.
          shreg_n = {data, shreg[DATA_BITS-1:1]};
          cnt_n   = CNT_MAX;
          idx_n   = idx + 1'b1;
          if (idx == IDX_LAST) begin
            state_n = STOP;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (data) begin
            frame_done = 1'b1;
            state_n    = IDLE;
          end else begin
            frame_err = 1'b1;
            state_n   = WAIT_IDLE;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      WAIT_IDLE: begin
        // Hold off re-arming the detector until the break ends.
        if (data) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register; detector reset follows the upcoming state so it re-arms at the stop edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      detector_rst <= 1'b1;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      idx          <= idx_n;
      shreg        <= shreg_n;
      detector_rst <= (state_n != IDLE);
    end
  end

  // One-entry output buffer with overrun and framing-error pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= frame_err;
      overrun       <= 1'b0;
      if (frame_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Bench for uart_rx_sequencer: behavioural line/detector driver, frame-level model, per-cycle compare.
module tb_uart_rx_sequencer;
  localparam int C = 16;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         data;
  logic         sbd;
  logic         rx_ready;
  logic         detector_rst;
  logic [N-1:0] rx_data;
  logic         rx_valid;
  logic         framing_error;
  logic         overrun;
  logic         busy;

  uart_rx_sequencer #(.CLKS_PER_BIT(C), .DATA_BITS(N)) dut (
    .clk(clk), .rst(rst), .data(data), .start_bit_detected(sbd),
    .detector_rst(detector_rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .framing_error(framing_error), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural start-bit detector: fires after 9 consecutive low clks while not in reset.
  int dcnt = 0;
  bit det_force = 1'b0;

  task automatic tick(input logic v, input logic r, input logic rs);
    @(negedge clk);
    data     = v;
    rx_ready = r;
    rst      = rs;
    if (det_force) sbd = 1'b1;
    else if (detector_rst !== 1'b0) begin
      dcnt = 0;
      sbd  = 1'b0;
    end else if (!sbd) begin
      if (!v) begin
        dcnt++;
        if (dcnt >= 9) sbd = 1'b1;
      end else dcnt = 0;
    end
  endtask

  task automatic idle(input int n, input logic r);
    repeat (n) tick(1'b1, r, 1'b1);
  endtask

  // Drive n_ticks clks of a frame: start bit, N data bits LSB-first, stop bit.
  task automatic frame(input logic [7:0] b, input logic stopv, input logic r,
                       input int acc_tick, input int n_ticks);
    for (int i = 0; i < n_ticks; i++) begin
      int   s;
      logic v;
      s = i / C;
      if (s == 0) v = 1'b0;
      else if (s <= N) v = b[s-1];
      else v = stopv;
      tick(v, (i == acc_tick) ? 1'b1 : r, 1'b1);
    end
  endtask

  // Frame-level model: positions counted in edges since the start was accepted.
  int           cyc = 0;
  int           mode = 0;   // 0 idle, 1 receiving, 2 waiting for line high
  int           age = 0;
  logic [N-1:0] m_bits = '0;
  logic         e_det_rst, e_busy, e_valid, e_fe, e_ov;
  logic [N-1:0] e_data;
  logic         sbd_prev = 1'b0, valid_prev = 1'b0;
  int           t_sbd = 0, t_valid = 0, fe_cnt = 0, ov_cnt = 0;

  always @(posedge clk) begin
    logic done;
    cyc++;
    done = 1'b0;
    if (sbd && !sbd_prev && mode == 0) t_sbd = cyc;
    sbd_prev = sbd;
    if (!rst) begin
      mode = 0; e_det_rst = 1'b1; e_valid = 1'b0; e_data = '0; e_fe = 1'b0; e_ov = 1'b0;
    end else begin
      e_fe = 1'b0;
      e_ov = 1'b0;
      if (mode == 0) begin
        if (sbd) begin
          mode = 1;
          age  = 0;
        end
      end else if (mode == 1) begin
        age++;
        if (age % C == 0 && age / C <= N) m_bits[age/C-1] = data;
        if (age == (N + 1) * C) begin
          if (data) begin
            done = 1'b1;
            mode = 0;
          end else begin
            e_fe = 1'b1;
            mode = 2;
          end
        end
      end else if (data) begin
        mode = 0;
      end
      if (done) begin
        if (!e_valid || rx_ready) begin
          e_data  = m_bits;
          e_valid = 1'b1;
        end else e_ov = 1'b1;
      end else if (e_valid && rx_ready) e_valid = 1'b0;
      e_det_rst = (mode != 0);
    end
    e_busy = (mode != 0);
    #1;
    chk("detector_rst", detector_rst, e_det_rst);
    chk("busy", busy, e_busy);
    chk("rx_valid", rx_valid, e_valid);
    chk("rx_data", rx_data, e_data);
    chk("framing_error", framing_error, e_fe);
    chk("overrun", overrun, e_ov);
    if (framing_error === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (rx_valid === 1'b1 && !valid_prev) t_valid = cyc;
    valid_prev = (rx_valid === 1'b1);
  end

  initial begin
    rst = 1'b0; data = 1'b0; sbd = 1'b1; rx_ready = 1'b0; det_force = 1'b1;
    // Reset with start asserted and line low.
    repeat (10) tick(1'b0, 1'b0, 1'b0);
    chk("lit_rst_det_rst", detector_rst, 1);
    chk("lit_rst_busy", busy, 0);
    chk("lit_rst_valid", rx_valid, 0);
    chk("lit_rst_pulses", {framing_error, overrun}, 0);
    det_force = 1'b0;
    tick(1'b1, 1'b0, 1'b1);
    chk("lit_release_det_rst_hi", detector_rst, 1);
    tick(1'b1, 1'b0, 1'b1);
    chk("lit_release_det_rst_lo", detector_rst, 0);
    idle(20, 1'b0);

    // Good frame, held until accepted.
    frame(8'hA5, 1'b1, 1'b0, -1, 10 * C);
    idle(30, 1'b0);
    chk("lit_a5_valid", rx_valid, 1);
    chk("lit_a5_data", rx_data, 8'hA5);
    chk("lit_a5_latency", t_valid - t_sbd, 144);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    chk("lit_a5_drop", rx_valid, 0);
    chk("lit_a5_hold_data", rx_data, 8'hA5);
    idle(10, 1'b0);

    // Framing error followed by a break, then a clean frame.
    frame(8'h3C, 1'b0, 1'b0, -1, 10 * C);
    repeat (40) tick(1'b0, 1'b0, 1'b1);
    chk("lit_fe_count", fe_cnt, 1);
    chk("lit_fe_valid", rx_valid, 0);
    chk("lit_fe_det_rst", detector_rst, 1);
    idle(20, 1'b0);
    chk("lit_fe_rearmed", detector_rst, 0);
    frame(8'h81, 1'b1, 1'b0, -1, 10 * C);
    idle(20, 1'b0);
    chk("lit_81_data", rx_data, 8'h81);
    tick(1'b1, 1'b1, 1'b1);
    idle(5, 1'b0);

    // Overrun: second byte dropped while the first is pending.
    frame(8'h11, 1'b1, 1'b0, -1, 10 * C);
    idle(20, 1'b0);
    frame(8'h22, 1'b1, 1'b0, -1, 10 * C);
    idle(20, 1'b0);
    chk("lit_ov_count", ov_cnt, 1);
    chk("lit_ov_data", rx_data, 8'h11);
    chk("lit_ov_valid", rx_valid, 1);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    chk("lit_ov_drop", rx_valid, 0);

    // Accept exactly on the completion edge (tick 152 precedes the stop-sample edge).
    frame(8'h11, 1'b1, 1'b0, -1, 10 * C);
    idle(20, 1'b0);
    frame(8'h22, 1'b1, 1'b0, 152, 10 * C);
    idle(20, 1'b0);
    chk("lit_sim_no_ov", ov_cnt, 1);
    chk("lit_sim_data", rx_data, 8'h22);
    chk("lit_sim_valid", rx_valid, 1);

    // Reset during data bit 3, with a byte still buffered.
    frame(8'h77, 1'b1, 1'b0, -1, 4 * C + 8);
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    chk("lit_mid_busy", busy, 0);
    chk("lit_mid_det_rst", detector_rst, 1);
    chk("lit_mid_valid", rx_valid, 0);
    tick(1'b1, 1'b0, 1'b1);
    idle(20, 1'b0);
    frame(8'h5A, 1'b1, 1'b0, -1, 10 * C);
    idle(20, 1'b0);
    chk("lit_5a_data", rx_data, 8'h5A);
    chk("lit_5a_valid", rx_valid, 1);
    chk("lit_fe_total", fe_cnt, 1);

    idle(3, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_sequencer.md
# uart_rx_sequencer

Receive-side controller for the UART. It arms the start-bit detector, times mid-bit sampling of the serial line once a start bit is confirmed, and assembles DATA_BITS bits LSB-first into a one-entry output buffer with valid/ready handshake. It also flags framing errors and overruns. It sits between the line synchronizer/start-bit detector and the byte consumer, and runs on the same oversampling clock as the detector.

## Interface
- CLKS_PER_BIT, default 16: clk cycles per bit period; minimum 2.
- DATA_BITS, default 8: data bits per frame; range 5..9.
- clk  in  1  oversampling clock; all logic rising-edge.
- rst  in  1  synchronous, active-low reset.
- data  in  1  serial line, already synchronized to clk; idle high.
- start_bit_detected  in  1  from start-bit detector; sticky high until the detector is reset.
- detector_rst  out  1  active-high reset to the start-bit detector.
- rx_data  out  DATA_BITS  buffered byte; bit 0 is the first received bit.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready.
- framing_error  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: completed byte dropped because the buffer was full.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, DATA, STOP, WAIT_IDLE.
- IDLE, start_bit_detected=1:
  - go to DATA.
  - load bit-period counter with CLKS_PER_BIT-1.
  - clear bit index.
- DATA:
  - counter decrements each clk.
  - at counter==0: shift data into shift register (LSB-first), reload counter, increment index.
  - after bit DATA_BITS-1 is sampled, go to STOP.
- STOP, at counter==0, sample data:
  - data=1: frame complete; go to IDLE.
  - data=0: framing_error pulse; frame discarded; go to WAIT_IDLE.
- WAIT_IDLE: stay while data=0; go to IDLE on the first clk with data=1. This blocks re-triggering during a break condition.
- detector_rst is registered and equals (next_state != IDLE). The detector is held in reset for the whole frame and re-armed on return to IDLE.
- Output buffer, on frame complete:
  - rx_valid=0, or rx_valid=1 with rx_ready=1 in the same cycle: load rx_data, rx_valid=1. Completion plus simultaneous acceptance gives no overrun.
  - rx_valid=1 and rx_ready=0: overrun pulse; new byte dropped; rx_data and rx_valid unchanged.
- rx_valid=1 and rx_ready=1 with no completion: rx_valid falls next cycle. rx_data holds its last value.
- rx_data and rx_valid never change while rx_valid=1 && rx_ready=0, except through reset.
- Bit-period counter width: $clog2(CLKS_PER_BIT). Bit index width: $clog2(DATA_BITS+1).

## Timing
- Reset values: state=IDLE, detector_rst=1, rx_valid=0, rx_data=0, framing_error=0, overrun=0, busy=0. detector_rst drops to 0 on the first clk after rst is released.
- Let T be the edge at which IDLE sees start_bit_detected=1.
  - detector_rst and busy are high from T+1.
  - Data bit k is sampled at edge T+(k+1)*CLKS_PER_BIT.
  - Stop bit is sampled at edge T+(DATA_BITS+1)*CLKS_PER_BIT; call this edge S.
- At S:
  - rx_valid/rx_data update, or framing_error/overrun pulse, visible after S for exactly one cycle (pulses).
  - busy and detector_rst fall after S on a good stop bit.
- Frame-to-frame: the detector is re-armed at S. The next start edge may arrive half a bit after S without loss.
- rst=0 mid-frame: next edge forces all reset values. The partial frame and any buffered byte are lost, with no error pulses.
- start_bit_detected is ignored outside IDLE.

## Test plan
- Reset: rst=0 for 10 clks with start_bit_detected=1 and data=0 -> detector_rst=1, rx_valid=0, busy=0, no pulses. After release, detector_rst=0 one clk later.
- Good frame: 0xA5, 16 clks/bit, behavioural detector (fires 9 clks after the falling edge) -> rx_valid rises the cycle after S=T+144, rx_data=0xA5. It stays high until rx_ready, then falls one clk after the accept.
- Framing error: 0x3C with stop bit 0 and line held low 40 more clks -> single-cycle framing_error after S, rx_valid stays 0, detector_rst=1 until data returns high. A following 0x81 frame is then received correctly.
- Overrun: frames 0x11 then 0x22 with rx_ready=0 -> one-cycle overrun at the second S, rx_data stays 0x11. Asserting rx_ready then drops rx_valid.
- Simultaneous accept: 0x11 pending, rx_ready=1 exactly on the second frame's completion cycle -> no overrun, rx_data=0x22, rx_valid stays 1.
- Reset mid-frame: rst=0 during data bit 3 -> next cycle IDLE, busy=0, detector_rst=1. After release, frame 0x5A is received correctly.
